// File: rtl/chimp_game_ctrl.sv
// Round sequencer for the chimp-test game: clears the board, loads 1..N, shows them,
// then checks the player's picks in order while tracking level, strikes and game-over.
module chimp_game_ctrl #(
  parameter int START_COUNT = 4,
  parameter int MAX_COUNT   = 25,
  parameter int MAX_STRIKES = 3
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iKey0,
  input  logic       iStart,
  input  logic       iDoneLoad,
  input  logic       iChoseCorrectNum,
  input  logic       iChoseWrongNum,
  output logic       oResetBoard,
  output logic       oLoadEnable,
  output logic [4:0] oNumToLoad,
  output logic       oShowEnable,
  output logic [4:0] oNumToChoose,
  output logic [4:0] oLevel,
  output logic [1:0] oStrikes,
  output logic       oRoundWin,
  output logic       oRoundLose,
  output logic       oGameOver,
  output logic       oGameWon
);

  localparam logic [4:0] START_L = 5'(START_COUNT);
  localparam logic [4:0] MAX_L   = 5'(MAX_COUNT);
  localparam logic [1:0] MAX_S   = 2'(MAX_STRIKES);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_SHOW, S_PLAY, S_WIN, S_LOSE, S_GAME_OVER
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] level_q, level_d;
  logic [4:0] load_cnt_q, load_cnt_d;
  logic [4:0] next_num_q, next_num_d;
  logic [1:0] strikes_q, strikes_d;
  logic       game_won_q, game_won_d;

  logic       reset_board_q, reset_board_d;
  logic       load_en_q, load_en_d;
  logic [4:0] num_to_load_q, num_to_load_d;
  logic       show_en_q, show_en_d;
  logic [4:0] num_to_choose_q, num_to_choose_d;
  logic       round_win_q, round_win_d;
  logic       round_lose_q, round_lose_d;
  logic       game_over_q, game_over_d;

  logic       abort;
  logic [1:0] strikes_inc;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    load_cnt_d  = load_cnt_q;
    next_num_d  = next_num_q;
    strikes_d   = strikes_q;
    game_won_d  = game_won_q;
    abort       = 1'b0;
    strikes_inc = (strikes_q < MAX_S) ? strikes_q + 2'd1 : strikes_q;

    if (iKey0 && (state_q != S_IDLE)) begin
      abort      = 1'b1;
      state_d    = S_IDLE;
      level_d    = START_L;
      load_cnt_d = 5'd1;
      next_num_d = 5'd1;
      strikes_d  = 2'd0;
      game_won_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_GAME_OVER: begin
          if (iStart) begin
            state_d    = S_CLEAR;
            level_d    = START_L;
            strikes_d  = 2'd0;
            game_won_d = 1'b0;
          end
        end
        S_CLEAR: begin
          load_cnt_d = 5'd1;
          next_num_d = 5'd1;
          state_d    = S_LOAD;
        end
        S_LOAD: begin
          if (iDoneLoad) begin
            if (load_cnt_q >= level_q) state_d = S_SHOW;
            else load_cnt_d = load_cnt_q + 5'd1;
          end
        end
        // A wrong pick dominates a simultaneous correct pick.
        S_SHOW: begin
          if (iChoseWrongNum) begin
            state_d   = S_LOSE;
            strikes_d = strikes_inc;
          end else if (iChoseCorrectNum) begin
            state_d    = S_PLAY;
            next_num_d = 5'd2;
          end
        end
        S_PLAY: begin
          if (iChoseWrongNum) begin
            state_d   = S_LOSE;
            strikes_d = strikes_inc;
          end else if (iChoseCorrectNum) begin
            if (next_num_q >= level_q) state_d = S_WIN;
            else next_num_d = next_num_q + 5'd1;
          end
        end
        S_WIN: begin
          if (level_q >= MAX_L) begin
            state_d    = S_GAME_OVER;
            game_won_d = 1'b1;
          end else begin
            state_d = S_CLEAR;
            level_d = level_q + 5'd1;
          end
        end
        S_LOSE: begin
          if (strikes_q >= MAX_S) begin
            state_d    = S_GAME_OVER;
            game_won_d = 1'b0;
          end else begin
            state_d = S_CLEAR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are a registered image of the next state, so they line up with state_q.
    reset_board_d   = abort || (state_d == S_CLEAR);
    load_en_d       = (state_d == S_LOAD);
    num_to_load_d   = (state_d == S_LOAD) ? load_cnt_d : 5'd0;
    show_en_d       = (state_d == S_SHOW) || (state_d == S_GAME_OVER);
    num_to_choose_d = (state_d == S_SHOW) ? 5'd1 :
                      (state_d == S_PLAY) ? next_num_d : 5'd0;
    round_win_d     = (state_d == S_WIN);
    round_lose_d    = (state_d == S_LOSE);
    game_over_d     = (state_d == S_GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q         <= S_IDLE;
      level_q         <= START_L;
      load_cnt_q      <= 5'd1;
      next_num_q      <= 5'd1;
      strikes_q       <= 2'd0;
      game_won_q      <= 1'b0;
      reset_board_q   <= 1'b0;
      load_en_q       <= 1'b0;
      num_to_load_q   <= 5'd0;
      show_en_q       <= 1'b0;
      num_to_choose_q <= 5'd0;
      round_win_q     <= 1'b0;
      round_lose_q    <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      level_q         <= level_d;
      load_cnt_q      <= load_cnt_d;
      next_num_q      <= next_num_d;
      strikes_q       <= strikes_d;
      game_won_q      <= game_won_d;
      reset_board_q   <= reset_board_d;
      load_en_q       <= load_en_d;
      num_to_load_q   <= num_to_load_d;
      show_en_q       <= show_en_d;
      num_to_choose_q <= num_to_choose_d;
      round_win_q     <= round_win_d;
      round_lose_q    <= round_lose_d;
      game_over_q     <= game_over_d;
    end
  end

  assign oResetBoard  = reset_board_q;
  assign oLoadEnable  = load_en_q;
  assign oNumToLoad   = num_to_load_q;
  assign oShowEnable  = show_en_q;
  assign oNumToChoose = num_to_choose_q;
  assign oLevel       = level_q;
  assign oStrikes     = strikes_q;
  assign oRoundWin    = round_win_q;
  assign oRoundLose   = round_lose_q;
  assign oGameOver    = game_over_q;
  assign oGameWon     = game_won_q;

endmodule

// File: tb/tb_chimp_game_ctrl.sv
// Directed bench for chimp_game_ctrl: expectations are queued alongside each stimulus
// step and drained against the DUT outputs one cycle later.
module tb_chimp_game_ctrl;

  logic       clk = 1'b0;
  logic       iReset, iKey0, iStart, iDoneLoad, iChoseCorrectNum, iChoseWrongNum;
  logic       oResetBoard, oLoadEnable, oShowEnable, oRoundWin, oRoundLose, oGameOver, oGameWon;
  logic [4:0] oNumToLoad, oNumToChoose, oLevel;
  logic [1:0] oStrikes;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  chimp_game_ctrl #(.START_COUNT(4), .MAX_COUNT(5), .MAX_STRIKES(3)) dut (
    .clk(clk), .iReset(iReset), .iKey0(iKey0), .iStart(iStart), .iDoneLoad(iDoneLoad),
    .iChoseCorrectNum(iChoseCorrectNum), .iChoseWrongNum(iChoseWrongNum),
    .oResetBoard(oResetBoard), .oLoadEnable(oLoadEnable), .oNumToLoad(oNumToLoad),
    .oShowEnable(oShowEnable), .oNumToChoose(oNumToChoose), .oLevel(oLevel),
    .oStrikes(oStrikes), .oRoundWin(oRoundWin), .oRoundLose(oRoundLose),
    .oGameOver(oGameOver), .oGameWon(oGameWon)
  );

  function automatic int observe(string t);
    case (t)
      "rb":     return int'(oResetBoard);
      "ld_en":  return int'(oLoadEnable);
      "ld_num": return int'(oNumToLoad);
      "show":   return int'(oShowEnable);
      "choose": return int'(oNumToChoose);
      "level":  return int'(oLevel);
      "strk":   return int'(oStrikes);
      "rwin":   return int'(oRoundWin);
      "rlose":  return int'(oRoundLose);
      "gover":  return int'(oGameOver);
      "gwon":   return int'(oGameWon);
      default:  return -1;
    endcase
  endfunction

  task automatic ex(string t, int v);
    exp_t e;
    e.tag = t;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    int   o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe(e.tag);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
    iStart = 0; iDoneLoad = 0; iChoseCorrectNum = 0; iChoseWrongNum = 0; iKey0 = 0;
  endtask

  // Just entered CLEAR: board clear pulse, then LOAD asking for number 1.
  task automatic expect_clear_then_load(int lvl, int strk);
    ex("rb", 1); ex("ld_en", 0); ex("level", lvl); ex("strk", strk); ex("rwin", 0); ex("rlose", 0);
  endtask

  task automatic load_round(int n, int gap_a, int gap_b);
    tick();
    ex("rb", 0); ex("ld_en", 1); ex("ld_num", 1);
    drain();
    for (int k = 1; k <= n; k++) begin
      for (int g = 0; g < ((k % 2 == 0) ? gap_b : gap_a); g++) begin
        ex("ld_en", 1); ex("ld_num", k);
        tick();
      end
      iDoneLoad = 1;
      if (k < n) begin
        ex("ld_en", 1); ex("ld_num", k + 1);
      end else begin
        ex("ld_en", 0); ex("show", 1); ex("choose", 1);
      end
      tick();
    end
  endtask

  task automatic win_round(int n);
    for (int k = 1; k <= n; k++) begin
      iChoseCorrectNum = 1;
      if (k < n) begin
        ex("show", 0); ex("choose", k + 1); ex("rwin", 0);
      end else begin
        ex("rwin", 1); ex("choose", 0);
      end
      tick();
    end
  endtask

  initial begin
    iReset = 1; iKey0 = 0; iStart = 0; iDoneLoad = 0; iChoseCorrectNum = 0; iChoseWrongNum = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ex("level", 4); ex("strk", 0); ex("rb", 0); ex("ld_en", 0); ex("ld_num", 0);
    ex("show", 0); ex("choose", 0); ex("gover", 0); ex("gwon", 0);
    drain();
    iReset = 0;

    // Inputs other than iStart are ignored in IDLE.
    iDoneLoad = 1; iChoseCorrectNum = 1; iKey0 = 1;
    ex("rb", 0); ex("ld_en", 0); ex("show", 0);
    tick();

    // Round 1 at level 4: two correct picks then a wrong one.
    iStart = 1;
    expect_clear_then_load(4, 0);
    tick();
    load_round(4, 0, 3);
    iChoseCorrectNum = 1;
    ex("show", 0); ex("choose", 2);
    tick();
    iChoseCorrectNum = 1;
    ex("choose", 3);
    tick();
    iChoseWrongNum = 1;
    ex("rlose", 1); ex("strk", 1); ex("level", 4);
    tick();
    expect_clear_then_load(4, 1);
    tick();
    load_round(4, 0, 0);

    // Simultaneous correct+wrong in PLAY counts as a strike.
    iChoseCorrectNum = 1;
    ex("choose", 2);
    tick();
    iChoseCorrectNum = 1; iChoseWrongNum = 1;
    ex("rlose", 1); ex("strk", 2);
    tick();
    expect_clear_then_load(4, 2);
    tick();
    load_round(4, 1, 0);

    // Third strike from SHOW ends the game.
    iChoseWrongNum = 1;
    ex("rlose", 1); ex("strk", 3);
    tick();
    ex("rlose", 0); ex("gover", 1); ex("gwon", 0); ex("strk", 3); ex("show", 1);
    tick();
    iChoseCorrectNum = 1;
    ex("gover", 1); ex("rb", 0);
    tick();

    // Fresh game from GAME_OVER, then abort mid-LOAD at loadCnt=2.
    iStart = 1;
    expect_clear_then_load(4, 0);
    ex("gover", 0);
    tick();
    ex("ld_en", 1); ex("ld_num", 1);
    tick();
    iDoneLoad = 1;
    ex("ld_num", 2);
    tick();
    iKey0 = 1;
    ex("rb", 1); ex("ld_en", 0); ex("ld_num", 0); ex("level", 4);
    tick();
    ex("rb", 0); ex("ld_en", 0);
    tick();

    // Clear levels 4 and 5 to win the game.
    iStart = 1;
    expect_clear_then_load(4, 0);
    tick();
    load_round(4, 0, 2);
    win_round(4);
    expect_clear_then_load(5, 0);
    tick();
    load_round(5, 0, 0);
    win_round(5);
    ex("gover", 1); ex("gwon", 1); ex("level", 5); ex("rwin", 0); ex("show", 1);
    tick();

    // Abort from GAME_OVER returns to IDLE and clears the won flag.
    iKey0 = 1;
    ex("rb", 1); ex("gover", 0); ex("gwon", 0); ex("level", 4); ex("show", 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
